// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner with per-press debounce.
// Emits a held key code, a held flag and a one-cycle accept pulse.
module keypad_scanner #(
  parameter int SCAN_DIV     = 4,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] keypad,
  output logic       key_valid,
  output logic       key_down
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD
  } state_t;

  state_t state, state_d;

  logic [3:0]    sync1, sync2;
  logic [DW-1:0] div;
  logic [1:0]    col, col_d;
  logic [1:0]    row, row_d;
  logic [CW-1:0] cnt, cnt_d, cnt_inc;
  logic [3:0]    keypad_d;
  logic          key_down_d, key_valid_d;

  logic          sample;
  logic [3:0]    low;
  logic          one_low;
  logic [1:0]    low_row;
  logic          hit;
  logic          same;
  logic          rel;
  logic [3:0]    code;
  logic          cnt_done;

  assign sample   = div == DW'(SCAN_DIV - 1);
  assign low      = ~sync2;
  assign hit      = one_low && !(low_row == 2'd3 && col == 2'd3);
  assign same     = sync2 == ~(4'b0001 << row);
  assign rel      = sync2[row];
  assign code     = {row, col} + 4'd1;
  assign cnt_inc  = cnt + CW'(1);
  assign cnt_done = cnt_inc == CW'(DEBOUNCE_CNT);
  assign col_out  = ~(4'b0001 << col);

  always_comb begin
    one_low = 1'b0;
    low_row = 2'd0;
    case (low)
      4'b0001: begin one_low = 1'b1; low_row = 2'd0; end
      4'b0010: begin one_low = 1'b1; low_row = 2'd1; end
      4'b0100: begin one_low = 1'b1; low_row = 2'd2; end
      4'b1000: begin one_low = 1'b1; low_row = 2'd3; end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state;
    col_d       = col;
    row_d       = row;
    cnt_d       = cnt;
    keypad_d    = keypad;
    key_down_d  = key_down;
    key_valid_d = 1'b0;
    unique case (state)
      SCAN: begin
        if (sample) begin
          if (hit) begin
            row_d   = low_row;
            cnt_d   = '0;
            state_d = DEBOUNCE;
          end else begin
            col_d = col + 2'd1;
          end
        end
      end
      DEBOUNCE: begin
        if (sample) begin
          if (same) begin
            cnt_d = cnt_inc;
            if (cnt_done) begin
              cnt_d       = '0;
              state_d     = HELD;
              keypad_d    = code;
              key_down_d  = 1'b1;
              key_valid_d = 1'b1;
            end
          end else begin
            state_d = SCAN;
            col_d   = col + 2'd1;
          end
        end
      end
      HELD: begin
        // only the latched row matters; other keys are ignored here
        if (sample) begin
          if (rel) begin
            cnt_d = cnt_inc;
            if (cnt_done) begin
              cnt_d      = '0;
              state_d    = SCAN;
              col_d      = 2'd0;
              keypad_d   = 4'd0;
              key_down_d = 1'b0;
            end
          end else begin
            cnt_d = '0;
          end
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= SCAN;
      sync1     <= 4'hF;
      sync2     <= 4'hF;
      div       <= '0;
      col       <= 2'd0;
      row       <= 2'd0;
      cnt       <= '0;
      keypad    <= 4'd0;
      key_down  <= 1'b0;
      key_valid <= 1'b0;
    end else begin
      state     <= state_d;
      sync1     <= row_in;
      sync2     <= sync1;
      div       <= sample ? '0 : div + DW'(1);
      col       <= col_d;
      row       <= row_d;
      cnt       <= cnt_d;
      keypad    <= keypad_d;
      key_down  <= key_down_d;
      key_valid <= key_valid_d;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural key matrix.
// Key index in keys is 4*row + col.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [3:0]  keypad;
  logic        key_valid;
  logic        key_down;
  logic [15:0] keys;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int viol   = 0;
  int nz     = 0;
  logic [3:0] prev = 4'd0;

  keypad_scanner #(
    .SCAN_DIV(4),
    .DEBOUNCE_CNT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .row_in(row_in),
    .col_out(col_out),
    .keypad(keypad),
    .key_valid(key_valid),
    .key_down(key_down)
  );

  always #5 clk = ~clk;

  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[4*r+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  always @(negedge clk) begin
    if (key_valid) pulses <= pulses + 1;
    if (keypad != 4'd0) nz <= nz + 1;
    if (prev != 4'd0 && keypad != 4'd0 && keypad != prev)
      viol <= viol + 1;
    prev <= keypad;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int base;
  int nz0;
  int n;

  initial begin
    rst  = 1'b0;
    keys = 16'h0;
    tick(3);
    check("rst_col", col_out, 4'b1110);
    check("rst_keypad", keypad, 0);
    check("rst_valid", key_valid, 0);
    check("rst_down", key_down, 0);
    rst = 1'b1;
    tick(2);

    base = pulses;
    for (int c = 0; c < 4; c++) begin
      keys = 16'h0;
      keys[c] = 1'b1;
      tick(150);
      check("row0_code", keypad, c + 1);
      keys = 16'h0;
      tick(100);
      check("row0_idle", keypad, 0);
    end
    check("row0_pulses", pulses - base, 4);

    base = pulses;
    keys = 16'h0;
    keys[6] = 1'b1;
    tick(300);
    check("hold_code", keypad, 7);
    check("hold_down", key_down, 1);
    check("hold_col", col_out, 4'b1011);
    check("hold_pulses", pulses - base, 1);
    keys = 16'h0;
    n = 0;
    while (keypad != 4'd0 && n < 40) begin
      tick(1);
      n++;
    end
    check("rel_latency", int'(n <= 19), 1);
    check("rel_col0", col_out, 4'b1110);
    tick(4);
    check("rescan_col1", col_out, 4'b1101);
    tick(60);

    base = pulses;
    for (int i = 0; i < 40; i++) begin
      keys = 16'h0;
      keys[0] = ((i / 3) % 2) == 0;
      tick(1);
    end
    keys = 16'h0;
    keys[0] = 1'b1;
    tick(100);
    check("bounce_pulses", pulses - base, 1);
    check("bounce_code", keypad, 1);
    keys = 16'h0;
    tick(60);

    base = pulses;
    nz0  = nz;
    keys[0] = 1'b1;
    tick(10);
    keys = 16'h0;
    tick(80);
    check("glitch_pulses", pulses - base, 0);
    check("glitch_keypad", nz - nz0, 0);

    base = pulses;
    nz0  = nz;
    keys = 16'h0;
    keys[1] = 1'b1;
    keys[9] = 1'b1;
    tick(150);
    check("ghost_pulses", pulses - base, 0);
    check("ghost_keypad", nz - nz0, 0);
    keys = 16'h0;
    tick(20);
    keys[15] = 1'b1;
    tick(150);
    check("k33_pulses", pulses - base, 0);
    check("k33_keypad", nz - nz0, 0);
    keys = 16'h0;
    tick(20);

    keys[6] = 1'b1;
    tick(100);
    check("pre_rst_code", keypad, 7);
    base = pulses;
    rst = 1'b0;
    #1;
    check("mid_rst_keypad", keypad, 0);
    check("mid_rst_down", key_down, 0);
    check("mid_rst_col", col_out, 4'b1110);
    tick(3);
    rst = 1'b1;
    tick(100);
    check("post_rst_pulses", pulses - base, 1);
    check("post_rst_code", keypad, 7);
    keys = 16'h0;
    tick(60);

    base = pulses;
    keys[6] = 1'b1;
    tick(100);
    check("two_first", keypad, 7);
    keys[0] = 1'b1;
    tick(50);
    check("two_ignored", keypad, 7);
    check("two_pulses1", pulses - base, 1);
    keys[6] = 1'b0;
    tick(150);
    check("two_second", keypad, 1);
    check("two_pulses2", pulses - base, 2);
    keys = 16'h0;
    tick(60);
    check("two_idle", keypad, 0);

    check("code_to_code", viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
